// File: rtl/aes_seq_pkg.sv
// Shared types, key-length encodings and round-count helpers for the AES round sequencer.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_ADD,
        S_SUB,
        S_SHIFT,
        S_MIX,
        S_DONE
    } seq_state_e;

    localparam logic [1:0] KEY_LEN_128  = 2'b00;
    localparam logic [1:0] KEY_LEN_192  = 2'b01;
    localparam logic [1:0] KEY_LEN_256  = 2'b10;
    localparam logic [1:0] KEY_LEN_RSVD = 2'b11;

    localparam int NR_128_DEF = 10;
    localparam int NR_192_DEF = 12;
    localparam int NR_256_DEF = 14;

    // Round counts are passed in so the top-level parameters stay authoritative.
    function automatic int nr_of(input logic [1:0] key_len, input int nr128,
                                 input int nr192, input int nr256);
        case (key_len)
            KEY_LEN_192: return nr192;
            KEY_LEN_256: return nr256;
            default:     return nr128;
        endcase
    endfunction

    // Decryption walks the key schedule backwards.
    function automatic int key_idx(input logic mode, input int nr, input int r);
        return mode ? (nr - r) : r;
    endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Round counter with clear/increment and a terminal flag (count == Nr), current and next.
module aes_round_cnt #(
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               inc,
    input  logic [ROUND_W-1:0] nr,
    output logic [ROUND_W-1:0] cnt,
    output logic [ROUND_W-1:0] cnt_next,
    output logic               term,
    output logic               term_next
);

    logic [ROUND_W-1:0] cnt_q;
    logic [ROUND_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + ROUND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign cnt_next  = cnt_d;
    assign term      = (cnt_q == nr);
    assign term_next = (cnt_d == nr);

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round controller: sequences key/add/sub/shift/mix strobes for enc/dec and 128/192/256.
// Optional macro AES_SEQ_STEP_HANDSHAKE_EN adds step_done so each step waits for its unit.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int ROUND_W = 4,
    parameter int NR_128  = NR_128_DEF,
    parameter int NR_192  = NR_192_DEF,
    parameter int NR_256  = NR_256_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               mode,
    input  logic [1:0]         key_len,
    input  logic               abort,
`ifdef AES_SEQ_STEP_HANDSHAKE_EN
    input  logic               step_done,
`endif
    output logic               key_start,
    output logic               add_start,
    output logic               sub_start,
    output logic               shift_start,
    output logic               mix_start,
    output logic               inv,
    output logic [ROUND_W-1:0] round_sel,
    output logic               init_sel,
    output logic               last_round,
    output logic               busy,
    output logic               done,
    output logic               err
);

    seq_state_e         state_q, state_d;
    logic               mode_q, mode_d;
    logic [ROUND_W-1:0] nr_q, nr_d;
    logic               key_start_q, key_start_d;
    logic               add_start_q, add_start_d;
    logic               sub_start_q, sub_start_d;
    logic               shift_start_q, shift_start_d;
    logic               mix_start_q, mix_start_d;
    logic [ROUND_W-1:0] round_sel_q, round_sel_d;
    logic               init_sel_q, init_sel_d;
    logic               last_round_q, last_round_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               adv;
    logic               cnt_clr;
    logic               cnt_inc;
    logic [ROUND_W-1:0] r_cnt;
    logic [ROUND_W-1:0] r_next;
    logic               r_term;
    logic               r_term_next;
    logic               is_step;
    logic               entering;

`ifdef AES_SEQ_STEP_HANDSHAKE_EN
    assign adv = step_done;
`else
    assign adv = 1'b1;
`endif

    aes_round_cnt #(
        .ROUND_W (ROUND_W)
    ) u_round_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .nr        (nr_q),
        .cnt       (r_cnt),
        .cnt_next  (r_next),
        .term      (r_term),
        .term_next (r_term_next)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        nr_d    = nr_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        err_d   = 1'b0;

        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (key_len == KEY_LEN_RSVD) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = S_KEY;
                            mode_d  = mode;
                            nr_d    = ROUND_W'(nr_of(key_len, NR_128, NR_192, NR_256));
                            cnt_clr = 1'b1;
                        end
                    end
                end
                S_KEY: begin
                    if (adv) state_d = S_ADD;
                end
                // ADD closes round 0, every encrypt round and the last decrypt round.
                S_ADD: begin
                    if (adv) begin
                        if (!mode_q || r_cnt == '0 || r_term) begin
                            cnt_inc = 1'b1;
                            if (r_term)      state_d = S_DONE;
                            else if (mode_q) state_d = S_SHIFT;
                            else             state_d = S_SUB;
                        end else begin
                            state_d = S_MIX;
                        end
                    end
                end
                S_SUB: begin
                    if (adv) state_d = mode_q ? S_ADD : S_SHIFT;
                end
                S_SHIFT: begin
                    if (adv) begin
                        if (mode_q)      state_d = S_SUB;
                        else if (r_term) state_d = S_ADD;
                        else             state_d = S_MIX;
                    end
                end
                S_MIX: begin
                    if (adv) begin
                        if (mode_q) begin
                            cnt_inc = 1'b1;
                            state_d = S_SHIFT;
                        end else begin
                            state_d = S_ADD;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so they line up with it once registered.
    always_comb begin
        is_step  = (state_d inside {S_KEY, S_ADD, S_SUB, S_SHIFT, S_MIX});
        entering = (state_d != state_q);

        key_start_d   = (state_d == S_KEY)   && entering;
        add_start_d   = (state_d == S_ADD)   && entering;
        sub_start_d   = (state_d == S_SUB)   && entering;
        shift_start_d = (state_d == S_SHIFT) && entering;
        mix_start_d   = (state_d == S_MIX)   && entering;

        round_sel_d = '0;
        if (is_step && state_d != S_KEY) begin
            round_sel_d = ROUND_W'(key_idx(mode_d, int'(nr_d), int'(r_next)));
        end
        init_sel_d   = (state_d == S_ADD) && (r_next == '0);
        last_round_d = is_step && (state_d != S_KEY) && r_term_next;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            nr_q          <= '0;
            key_start_q   <= 1'b0;
            add_start_q   <= 1'b0;
            sub_start_q   <= 1'b0;
            shift_start_q <= 1'b0;
            mix_start_q   <= 1'b0;
            round_sel_q   <= '0;
            init_sel_q    <= 1'b0;
            last_round_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            nr_q          <= nr_d;
            key_start_q   <= key_start_d;
            add_start_q   <= add_start_d;
            sub_start_q   <= sub_start_d;
            shift_start_q <= shift_start_d;
            mix_start_q   <= mix_start_d;
            round_sel_q   <= round_sel_d;
            init_sel_q    <= init_sel_d;
            last_round_q  <= last_round_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign key_start   = key_start_q;
    assign add_start   = add_start_q;
    assign sub_start   = sub_start_q;
    assign shift_start = shift_start_q;
    assign mix_start   = mix_start_q;
    assign inv         = mode_q;
    assign round_sel   = round_sel_q;
    assign init_sel    = init_sel_q;
    assign last_round  = last_round_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
